// File: rtl/warp_seq.sv
// Warp mesh sequencer: walks the tile grid, fetches four corner
// vertices per tile and hands each tile job to the warp datapath.
module warp_seq (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [6:0]  meshcountx,
  input  logic [6:0]  meshcounty,
  input  logic [10:0] meshsizex,
  input  logic [10:0] meshsizey,
  input  logic [29:0] meshaddr,
  output logic        mem_stb,
  output logic [31:0] mem_adr,
  input  logic        mem_ack,
  input  logic [31:0] mem_dat,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [10:0] tile_x,
  output logic [10:0] tile_y,
  output logic [31:0] tile_v0,
  output logic [31:0] tile_v1,
  output logic [31:0] tile_v2,
  output logic [31:0] tile_v3
);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, NEXT, FIN
  } state_t;

  state_t state_q, state_d;

  logic [6:0]  cx_q, cy_q, i_q, j_q;
  logic [10:0] sx_q, sy_q, x_q, y_q;
  logic [29:0] rowbase_q, wadr;
  logic [1:0]  k_q;
  logic        gap_q, skip_q;
  logic [3:0][31:0] v_q;
  logic        degen, ack_hit;
  logic        last_col, last_row;

  assign degen   = (meshcountx < 7'd2)
                || (meshcounty < 7'd2);
  assign mem_stb = (state_q == FETCH) && !gap_q;
  assign ack_hit = mem_stb && mem_ack;

  assign last_col = ({1'b0, i_q} + 8'd2)
                 >= {1'b0, cx_q};
  assign last_row = ({1'b0, j_q} + 8'd2)
                 >= {1'b0, cy_q};

  // k[1] selects the lower row, k[0] the right column
  assign wadr = rowbase_q
              + {23'd0, i_q}
              + (k_q[1] ? {23'd0, cx_q} : 30'd0)
              + {29'd0, k_q[0]};

  assign mem_adr    = {wadr, 2'b00};
  assign busy       = (state_q != IDLE) && !skip_q;
  assign done       = (state_q == FIN);
  assign tile_valid = (state_q == ISSUE);
  assign tile_x     = x_q;
  assign tile_y     = y_q;
  assign tile_v0    = v_q[0];
  assign tile_v1    = v_q[1];
  assign tile_v2    = v_q[2];
  assign tile_v3    = v_q[3];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) state_d = degen ? FIN : FETCH;
      FETCH:
        if (ack_hit && k_q == 2'd3) state_d = ISSUE;
      ISSUE:
        if (tile_ready) state_d = NEXT;
      NEXT:
        if (!last_col || !last_row) state_d = FETCH;
        else                        state_d = FIN;
      FIN:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cx_q      <= '0;
      cy_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rowbase_q <= '0;
      k_q       <= '0;
      gap_q     <= 1'b0;
      skip_q    <= 1'b0;
      v_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cx_q      <= meshcountx;
          cy_q      <= meshcounty;
          sx_q      <= meshsizex;
          sy_q      <= meshsizey;
          rowbase_q <= meshaddr;
          i_q       <= '0;
          j_q       <= '0;
          x_q       <= '0;
          y_q       <= '0;
          k_q       <= '0;
          gap_q     <= 1'b0;
          skip_q    <= degen;
        end
        FETCH: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (mem_ack) begin
            v_q[k_q] <= mem_dat;
            k_q      <= k_q + 2'd1;
            gap_q    <= (k_q != 2'd3);
          end
        end
        NEXT: begin
          if (!last_col) begin
            i_q <= i_q + 7'd1;
            x_q <= x_q + sx_q;
          end else if (!last_row) begin
            i_q       <= '0;
            j_q       <= j_q + 7'd1;
            rowbase_q <= rowbase_q + {23'd0, cx_q};
            x_q       <= '0;
            y_q       <= y_q + sy_q;
          end
        end
        FIN: skip_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_seq.sv
// Directed bench for warp_seq: vector table of mesh passes plus
// hand sequences for back-pressure, reset and degenerate timing.
module tb_warp_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [6:0]  meshcountx = '0, meshcounty = '0;
  logic [10:0] meshsizex = '0, meshsizey = '0;
  logic [29:0] meshaddr = '0;
  logic        mem_stb;
  logic [31:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_dat = '0;
  logic        tile_valid;
  logic        tile_ready = 1'b1;
  logic [10:0] tile_x, tile_y;
  logic [31:0] tile_v0, tile_v1, tile_v2, tile_v3;

  warp_seq dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .start(start), .busy(busy), .done(done),
    .meshcountx(meshcountx), .meshcounty(meshcounty),
    .meshsizex(meshsizex), .meshsizey(meshsizey),
    .meshaddr(meshaddr),
    .mem_stb(mem_stb), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_dat(mem_dat),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_x(tile_x), .tile_y(tile_y),
    .tile_v0(tile_v0), .tile_v1(tile_v1),
    .tile_v2(tile_v2), .tile_v3(tile_v3)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [6:0]  cx, cy;
    logic [10:0] sx, sy;
    logic [29:0] addr;
    int          wt;
    int          ntile;
    int          nfetch;
    logic        bsy;
    logic [10:0] lx, ly;
    logic [29:0] br;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int   ack_wait = 0;
  int   wcnt = 0;
  logic resp_en = 1'b1;
  logic inj_ack = 1'b0;
  logic stb_hold = 1'b0;
  logic [31:0] hold_adr = '0;
  int   adr_err = 0;
  int   stb_cnt = 0;
  logic busy_seen = 1'b0;

  logic [31:0] fetch_q[$];
  logic [10:0] tx_q[$], ty_q[$];
  logic [31:0] t0_q[$], t1_q[$], t2_q[$], t3_q[$];

  // memory responder and tile monitor, all on the falling edge
  initial forever begin
    @(negedge wb_clk_i);
    if (mem_stb) stb_cnt++;
    if (busy) busy_seen = 1'b1;
    if (tile_valid && tile_ready) begin
      tx_q.push_back(tile_x);
      ty_q.push_back(tile_y);
      t0_q.push_back(tile_v0);
      t1_q.push_back(tile_v1);
      t2_q.push_back(tile_v2);
      t3_q.push_back(tile_v3);
    end
    if (inj_ack) begin
      mem_ack = 1'b1;
      mem_dat = 32'hBAD0_BAD0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_stb && resp_en) begin
      if (stb_hold && mem_adr != hold_adr) adr_err++;
      hold_adr = mem_adr;
      stb_hold = 1'b1;
      if (wcnt >= ack_wait) begin
        mem_ack = 1'b1;
        mem_dat = {2'b10, mem_adr[31:2]};
        fetch_q.push_back(mem_adr);
        wcnt = 0;
        stb_hold = 1'b0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      stb_hold = 1'b0;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clear_logs();
    fetch_q.delete();
    tx_q.delete(); ty_q.delete();
    t0_q.delete(); t1_q.delete();
    t2_q.delete(); t3_q.delete();
    busy_seen = 1'b0;
    adr_err = 0;
  endtask

  task automatic setup(input vec_t v);
    meshcountx = v.cx;
    meshcounty = v.cy;
    meshsizex  = v.sx;
    meshsizey  = v.sy;
    meshaddr   = v.addr;
    ack_wait   = v.wt;
    clear_logs();
  endtask

  task automatic scramble();
    meshcountx = 7'd0;
    meshcounty = 7'd0;
    meshsizex  = 11'h7FF;
    meshsizey  = 11'h7FF;
    meshaddr   = 30'h2AAA_AAAA;
  endtask

  task automatic wait_done(input int lim,
                           output logic got);
    int c;
    c = 0;
    got = done;
    while (!got && c < lim) begin
      step();
      got = done;
      c++;
    end
  endtask

  task automatic run_pass(input vec_t v);
    logic got;
    setup(v);
    start = 1'b1;
    step();
    start = 1'b0;
    scramble();
    wait_done(2000, got);
    chk("done_seen", {31'd0, got}, 32'd1);
    step();
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  vec_t tbl[7];
  vec_t v;
  logic got;
  logic [10:0] sx0, sy0;
  logic [31:0] s0, s1, s2, s3;
  int   c, sc;

  initial begin
    tbl[0] = '{7'd2, 7'd2, 11'd16, 11'd16, 30'h100,
               1, 1, 4, 1'b1, 11'd0, 11'd0, 30'h103};
    tbl[1] = '{7'd3, 7'd3, 11'd26, 11'd26, 30'h200,
               0, 4, 16, 1'b1, 11'd26, 11'd26, 30'h208};
    tbl[2] = '{7'd4, 7'd2, 11'd100, 11'd50, 30'h1000,
               2, 3, 12, 1'b1, 11'd200, 11'd0, 30'h1007};
    tbl[3] = '{7'd2, 7'd5, 11'd5, 11'd1000, 30'h40,
               0, 4, 16, 1'b1, 11'd0, 11'd952, 30'h49};
    tbl[4] = '{7'd2, 7'd2, 11'd8, 11'd8, 30'h3FFF_FFFF,
               0, 1, 4, 1'b1, 11'd0, 11'd0, 30'h2};
    tbl[5] = '{7'd1, 7'd16, 11'd8, 11'd8, 30'h80,
               0, 0, 0, 1'b0, 11'd0, 11'd0, 30'h0};
    tbl[6] = '{7'd5, 7'd0, 11'd8, 11'd8, 30'h80,
               0, 0, 0, 1'b0, 11'd0, 11'd0, 30'h0};

    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stb", {31'd0, mem_stb}, 32'd0);
    chk("rst_tvalid", {31'd0, tile_valid}, 32'd0);
    chk("rst_v0", tile_v0, 32'd0);
    wb_rst_i = 1'b0;
    step();

    for (int n = 0; n < 7; n++) begin
      run_pass(tbl[n]);
      chk("tiles", tx_q.size(), tbl[n].ntile);
      chk("fetches", fetch_q.size(), tbl[n].nfetch);
      chk("busy_seen", {31'd0, busy_seen},
          {31'd0, tbl[n].bsy});
      chk("adr_stable", adr_err, 0);
      if (tbl[n].nfetch > 0 && fetch_q.size() > 0)
        chk("first_adr", fetch_q[0],
            {tbl[n].addr, 2'b00});
      if (tbl[n].ntile > 0 && tx_q.size() > 0) begin
        chk("first_x", {21'd0, tx_q[0]}, 32'd0);
        chk("first_y", {21'd0, ty_q[0]}, 32'd0);
        chk("last_x", {21'd0, tx_q[tx_q.size()-1]},
            {21'd0, tbl[n].lx});
        chk("last_y", {21'd0, ty_q[ty_q.size()-1]},
            {21'd0, tbl[n].ly});
        chk("last_br", t3_q[t3_q.size()-1],
            {2'b10, tbl[n].br});
      end
    end

    // minimal grid: exact fetch sequence
    run_pass(tbl[0]);
    chk("min_n", fetch_q.size(), 4);
    if (fetch_q.size() == 4) begin
      chk("min_a0", fetch_q[0], 32'h400);
      chk("min_a1", fetch_q[1], 32'h404);
      chk("min_a2", fetch_q[2], 32'h408);
      chk("min_a3", fetch_q[3], 32'h40C);
    end

    // 3x3 walk order and all corners of the last tile
    run_pass(tbl[1]);
    chk("walk_n", tx_q.size(), 4);
    if (tx_q.size() == 4) begin
      chk("walk_x1", {21'd0, tx_q[1]}, 32'd26);
      chk("walk_y1", {21'd0, ty_q[1]}, 32'd0);
      chk("walk_x2", {21'd0, tx_q[2]}, 32'd0);
      chk("walk_y2", {21'd0, ty_q[2]}, 32'd26);
      chk("walk_v0", t0_q[3], {2'b10, 30'h204});
      chk("walk_v1", t1_q[3], {2'b10, 30'h205});
      chk("walk_v2", t2_q[3], {2'b10, 30'h207});
      chk("walk_v3", t3_q[3], {2'b10, 30'h208});
    end

    // wrap-around of the word address
    run_pass(tbl[4]);
    if (fetch_q.size() > 1)
      chk("wrap_tr", fetch_q[1], 32'h0);
    else
      chk("wrap_cnt", fetch_q.size(), 4);

    // degenerate: done the cycle right after start
    setup(tbl[5]);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("deg_done", {31'd0, done}, 32'd1);
    chk("deg_busy", {31'd0, busy}, 32'd0);
    chk("deg_stb", {31'd0, mem_stb}, 32'd0);
    step();
    chk("deg_done_pulse", {31'd0, done}, 32'd0);
    chk("deg_busy_seen", {31'd0, busy_seen}, 32'd0);

    // back-pressure with a start strobe while busy
    v = tbl[0];
    v.wt = 0;
    setup(v);
    tile_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (!tile_valid && c < 200) begin
      step();
      c++;
    end
    chk("bp_valid", {31'd0, tile_valid}, 32'd1);
    sx0 = tile_x; sy0 = tile_y;
    s0 = tile_v0; s1 = tile_v1;
    s2 = tile_v2; s3 = tile_v3;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      chk("bp_hold_valid", {31'd0, tile_valid}, 32'd1);
      chk("bp_hold_x", {21'd0, tile_x}, {21'd0, sx0});
      chk("bp_hold_y", {21'd0, tile_y}, {21'd0, sy0});
      chk("bp_hold_v0", tile_v0, s0);
      chk("bp_hold_v3", tile_v3, s3);
    end
    chk("bp_v1", s1, {2'b10, 30'h101});
    chk("bp_v2", s2, {2'b10, 30'h102});
    tile_ready = 1'b1;
    wait_done(200, got);
    chk("bp_done", {31'd0, got}, 32'd1);
    for (int k = 0; k < 20; k++) step();
    chk("bp_busy", {31'd0, busy}, 32'd0);
    chk("bp_tiles", tx_q.size(), 1);
    chk("bp_fetches", fetch_q.size(), 4);

    // reset during the 3rd fetch of the second tile
    v = tbl[0];
    v.cx = 7'd3; v.cy = 7'd2;
    v.addr = 30'h500; v.wt = 3;
    setup(v);
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (!(fetch_q.size() == 6 && mem_stb) && c < 500) begin
      step();
      c++;
    end
    chk("mr_reach", fetch_q.size(), 6);
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    resp_en = 1'b0;
    inj_ack = 1'b1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_stb", {31'd0, mem_stb}, 32'd0);
    chk("mr_adr", mem_adr, 32'd0);
    chk("mr_tvalid", {31'd0, tile_valid}, 32'd0);
    chk("mr_tx", {21'd0, tile_x}, 32'd0);
    chk("mr_v0", tile_v0, 32'd0);
    chk("mr_v3", tile_v3, 32'd0);
    sc = stb_cnt;
    step();
    inj_ack = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("mr_idle_busy", {31'd0, busy}, 32'd0);
    chk("mr_no_resume", stb_cnt - sc, 0);
    chk("mr_ack_ignored", tile_v0, 32'd0);
    resp_en = 1'b1;
    v.wt = 0;
    run_pass(v);
    chk("mr_tiles", tx_q.size(), 2);
    if (fetch_q.size() > 0)
      chk("mr_tl", fetch_q[0], {30'h500, 2'b00});
    if (tx_q.size() > 0)
      chk("mr_first_x", {21'd0, tx_q[0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
